// File: rtl/argmax_pkg.sv
// Shared defaults and FSM state type for the argmax controller slice.
package argmax_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int LEN_W_DEF  = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/argmax_max_compare_unit.sv
// Running-maximum register with a signed strictly-greater comparator.
module max_compare_unit
   import argmax_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_first,
   input  logic              update_en,
   input  logic [DATA_W-1:0] in_data,
   output logic [DATA_W-1:0] max,
   output logic              is_greater
);

   logic [DATA_W-1:0] r_max;

   assign is_greater = $signed(in_data) > $signed(r_max);
   assign max        = r_max;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_max <= '0;
      end else if (load_first || (update_en && is_greater)) begin
         r_max <= in_data;
      end
   end

endmodule

// File: rtl/argmax_controller.sv
// Streams a vector of signed elements and reports the largest value and the
// index of its first occurrence.
module argmax_controller
   import argmax_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] res_max,
   output logic [LEN_W-1:0]  res_idx,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              err
);

   state_t             r_state;
   logic [LEN_W-1:0]   r_len;
   logic [LEN_W-1:0]   r_cnt;
   logic [LEN_W-1:0]   r_idx;
   logic               r_busy;
   logic               r_in_ready;
   logic               r_res_valid;
   logic               r_err;

   logic               w_accept;
   logic               w_first;
   logic               w_update;
   logic               w_last;
   logic               w_is_greater;
   logic [DATA_W-1:0]  w_max;

   assign w_accept = in_valid && r_in_ready;
   assign w_first  = w_accept && (r_cnt == '0);
   assign w_update = w_accept && (r_cnt != '0);
   assign w_last   = (r_cnt == r_len - LEN_W'(1));

   max_compare_unit #(
      .DATA_W (DATA_W)
   ) u_cmp (
      .clk        (clk),
      .reset      (reset),
      .load_first (w_first),
      .update_en  (w_update),
      .in_data    (in_data),
      .max        (w_max),
      .is_greater (w_is_greater)
   );

   // Handshake outputs are registered alongside the state so they change on
   // the same edge as the transition that implies them.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_len       <= '0;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_busy      <= 1'b0;
         r_in_ready  <= 1'b0;
         r_res_valid <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  if (len != '0) begin
                     r_len      <= len;
                     r_cnt      <= '0;
                     r_state    <= RUN;
                     r_busy     <= 1'b1;
                     r_in_ready <= 1'b1;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (w_accept) begin
                  r_cnt <= r_cnt + LEN_W'(1);
                  if (w_first) begin
                     r_idx <= '0;
                  end else if (w_is_greater) begin
                     r_idx <= r_cnt;
                  end
                  if (w_last) begin
                     r_state     <= DONE;
                     r_in_ready  <= 1'b0;
                     r_res_valid <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (res_ready) begin
                  r_state     <= IDLE;
                  r_busy      <= 1'b0;
                  r_res_valid <= 1'b0;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_busy      <= 1'b0;
               r_in_ready  <= 1'b0;
               r_res_valid <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign in_ready  = r_in_ready;
   assign res_valid = r_res_valid;
   assign err       = r_err;
   assign res_max   = w_max;
   assign res_idx   = r_idx;

endmodule

// File: tb/tb_argmax_controller.sv
// Table-driven and randomized checks of argmax_controller against a
// behavioural first-index-of-maximum model.
module tb_argmax_controller;
   import argmax_pkg::*;

   localparam int DW = 32;
   localparam int LW = 10;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [LW-1:0] len = '0;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          res_ready = 1'b0;
   logic          busy, in_ready, res_valid, err;
   logic [DW-1:0] res_max;
   logic [LW-1:0] res_idx;

   argmax_controller #(
      .DATA_W (DW),
      .LEN_W  (LW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .len       (len),
      .busy      (busy),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .res_max   (res_max),
      .res_idx   (res_idx),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .err       (err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   logic [DW-1:0] g_data[$];

   typedef struct packed {
      logic [LW-1:0]          len;
      logic [3:0][DW-1:0]     d;
      logic [DW-1:0]          emax;
      logic [LW-1:0]          eidx;
   } vec_t;

   vec_t tbl[4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Largest signed value first, then the lowest position holding it.
   task automatic model(output logic [DW-1:0] mx, output logic [LW-1:0] ix);
      int best;
      best = $signed(g_data[0]);
      foreach (g_data[i]) if ($signed(g_data[i]) > best) best = $signed(g_data[i]);
      mx = DW'(best);
      ix = '0;
      for (int i = g_data.size() - 1; i >= 0; i--) if (g_data[i] == mx) ix = LW'(i);
   endtask

   task automatic run_vec(input string name, input int gmin, input int gmax, input int hold,
                          input logic [DW-1:0] emax, input logic [LW-1:0] eidx,
                          input bit start_in_done);
      int n;
      n = g_data.size();
      len = LW'(n);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({name, ":busy"}, 64'(busy), 64'd1);
      chk({name, ":in_ready"}, 64'(in_ready), 64'd1);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(gmax, gmin)) tick();
         in_data  = g_data[i];
         in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
      end
      chk({name, ":res_valid"}, 64'(res_valid), 64'd1);
      chk({name, ":in_ready_done"}, 64'(in_ready), 64'd0);
      chk({name, ":res_max"}, 64'(res_max), 64'(emax));
      chk({name, ":res_idx"}, 64'(res_idx), 64'(eidx));
      for (int h = 0; h < hold; h++) begin
         if (start_in_done && h == 1) begin
            start = 1'b1;
            len   = '0;
         end
         tick();
         start = 1'b0;
         chk({name, ":hold_valid"}, 64'(res_valid), 64'd1);
         chk({name, ":hold_max"}, 64'(res_max), 64'(emax));
         chk({name, ":hold_idx"}, 64'(res_idx), 64'(eidx));
         chk({name, ":hold_err"}, 64'(err), 64'd0);
         chk({name, ":hold_busy"}, 64'(busy), 64'd1);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk({name, ":idle_busy"}, 64'(busy), 64'd0);
      chk({name, ":idle_valid"}, 64'(res_valid), 64'd0);
      chk({name, ":idle_max"}, 64'(res_max), 64'(emax));
      chk({name, ":idle_idx"}, 64'(res_idx), 64'(eidx));
   endtask

   initial begin
      logic [DW-1:0] mx;
      logic [LW-1:0] ix;
      int            n;

      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_valid", 64'(res_valid), 64'd0);
      chk("rst_max", 64'(res_max), 64'd0);
      chk("rst_idx", 64'(res_idx), 64'd0);
      tick();
      tick();
      reset = 1'b1;
      tick();
      chk("post_rst_ready", 64'(in_ready), 64'd0);
      chk("post_rst_err", 64'(err), 64'd0);

      tbl[0] = '{len: 4, d: {32'h0180_0000, 32'h0280_0000, 32'h0380_0000, 32'h0080_0000},
                 emax: 32'h0380_0000, eidx: 1};
      tbl[1] = '{len: 4, d: {32'hFF00_0000, 32'hFC00_0000, 32'hFD00_0000, 32'hFE00_0000},
                 emax: 32'hFF00_0000, eidx: 3};
      tbl[2] = '{len: 3, d: {32'h0, 32'h0000_0000, 32'h0400_0000, 32'h0400_0000},
                 emax: 32'h0400_0000, eidx: 0};
      tbl[3] = '{len: 4, d: {32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000},
                 emax: 32'h7FFF_FFFF, eidx: 1};
      for (int t = 0; t < 4; t++) begin
         g_data.delete();
         for (int j = 0; j < int'(tbl[t].len); j++) g_data.push_back(tbl[t].d[j]);
         run_vec($sformatf("tbl%0d", t), 0, 0, 0, tbl[t].emax, tbl[t].eidx, 1'b0);
      end

      len   = '0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("len0_err", 64'(err), 64'd1);
      chk("len0_busy", 64'(busy), 64'd0);
      tick();
      chk("len0_err_drop", 64'(err), 64'd0);
      chk("len0_busy2", 64'(busy), 64'd0);
      g_data.delete();
      g_data.push_back(32'hFF00_0000);
      run_vec("len1", 0, 0, 0, 32'hFF00_0000, 0, 1'b0);

      g_data.delete();
      g_data.push_back(32'h0100_0000);
      g_data.push_back(32'h0200_0000);
      run_vec("gaps", 3, 3, 5, 32'h0200_0000, 1, 1'b1);
      tick();
      chk("gaps_no_restart", 64'(busy), 64'd0);
      chk("gaps_no_err", 64'(err), 64'd0);

      len   = LW'(4);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_data  = 32'h0500_0000 + DW'(i);
         in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
      end
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_ready", 64'(in_ready), 64'd0);
      chk("mid_rst_valid", 64'(res_valid), 64'd0);
      chk("mid_rst_max", 64'(res_max), 64'd0);
      chk("mid_rst_idx", 64'(res_idx), 64'd0);
      tick();
      reset = 1'b1;
      for (int c = 0; c < 6; c++) begin
         in_data  = 32'h0600_0000;
         in_valid = 1'b1;
         tick();
         chk("after_rst_valid", 64'(res_valid), 64'd0);
         chk("after_rst_busy", 64'(busy), 64'd0);
      end
      in_valid = 1'b0;
      g_data.delete();
      g_data.push_back(32'h0123_4567);
      run_vec("after_rst_len1", 0, 0, 1, 32'h0123_4567, 0, 1'b0);

      for (int r = 0; r < 25; r++) begin
         g_data.delete();
         n = $urandom_range(12, 1);
         for (int j = 0; j < n; j++) begin
            case ($urandom_range(5, 0))
               0: g_data.push_back(32'h0400_0000);
               1: g_data.push_back(32'hFF00_0000);
               2: g_data.push_back(32'h8000_0000);
               3: g_data.push_back(32'h7FFF_FFFF);
               default: g_data.push_back($urandom);
            endcase
         end
         model(mx, ix);
         run_vec($sformatf("rnd%0d", r), 0, 3, $urandom_range(2, 0), mx, ix, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/argmax_controller.md
ARGMAX_CONTROLLER -- requirements
Module: argmax_controller

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the element width in signed Q8.24 fixed point.
REQ-002 The block SHALL have parameter LEN_W, default 10, giving the width of the vector-length and index fields.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port start  input  1  one-cycle request to begin a new vector.
REQ-006 The block SHALL have port len  input  LEN_W  element count, sampled when start is accepted.
REQ-007 The block SHALL have port busy  output  1  high whenever the block is not in IDLE.
REQ-008 The block SHALL have port in_data  input  DATA_W  signed Q8.24 element.
REQ-009 The block SHALL have port in_valid  input  1  in_data holds a valid element.
REQ-010 The block SHALL have port in_ready  output  1  the block accepts an element this cycle.
REQ-011 The block SHALL have port res_max  output  DATA_W  the largest element of the vector.
REQ-012 The block SHALL have port res_idx  output  LEN_W  the zero-based position of res_max.
REQ-013 The block SHALL have port res_valid  output  1  res_max and res_idx are valid.
REQ-014 The block SHALL have port res_ready  input  1  the consumer takes the result.
REQ-015 The block SHALL have port err  output  1  one-cycle pulse when start is rejected.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-017 In IDLE, start=1 with len!=0 SHALL latch len, clear the element count and go to RUN on the next edge.
REQ-018 In IDLE, start=1 with len==0 SHALL pulse err for exactly one cycle and remain in IDLE.
REQ-019 start SHALL be ignored in RUN and DONE: no err pulse and no change to the latched len.
REQ-020 in_ready SHALL be 1 only in RUN; an element is accepted when in_valid and in_ready are both 1.
REQ-021 The first accepted element SHALL load max unconditionally with idx=0.
REQ-022 Each later element SHALL replace max and idx only when it is strictly greater, by signed two's-complement comparison; ties SHALL keep the earliest index.
REQ-023 Cycles in which in_valid=0 during RUN SHALL leave all state unchanged; gaps of any length are legal.
REQ-024 The accept of element number len-1 SHALL move the FSM to DONE, with res_valid=1 on the following cycle (one cycle of latency).
REQ-025 In DONE, res_max, res_idx and res_valid SHALL stay stable until res_ready=1; that cycle SHALL complete the transfer and return the FSM to IDLE.
REQ-026 Back-to-back operation SHALL be supported: a start in the first IDLE cycle after DONE SHALL be accepted.
REQ-027 res_max and res_idx SHALL hold their last values while in IDLE.
REQ-028 The element counter SHALL be LEN_W bits wide and SHALL never wrap, because the maximum len is 2^LEN_W-1.
REQ-029 No arithmetic SHALL be performed on the data beyond the signed compare; the stored value SHALL be bit-exact with the input.

Reset
REQ-030 reset=0 SHALL asynchronously force the FSM to IDLE and clear the counter, latched len, max and idx.
REQ-031 During and after reset, busy, in_ready, res_valid, err, res_max and res_idx SHALL all be 0.
REQ-032 A reset asserted mid-RUN or mid-DONE SHALL abandon the vector; no partial result SHALL be presented afterwards.
REQ-033 The block SHALL leave reset on the first rising clk edge after reset=1.

Structure
REQ-034 The shared package argmax_pkg SHALL hold DATA_W and LEN_W defaults and the state typedef (IDLE, RUN, DONE).
REQ-035 The running max register and signed comparator SHALL live in sub-module max_compare_unit, with inputs load_first and update_en and outputs max and is_greater.
REQ-036 The top level SHALL hold the FSM, counter, index tracking and handshakes.

Verification
REQ-037 Scenario: len=4 with inputs 0x0080_0000, 0x0380_0000, 0x0280_0000, 0x0180_0000 -> res_max=0x0380_0000 and res_idx=1.
REQ-038 Scenario: len=4 with inputs 0xFE00_0000, 0xFD00_0000, 0xFC00_0000, 0xFF00_0000 -> res_max=0xFF00_0000 and res_idx=3.
REQ-039 Scenario: len=3 with inputs 0x0400_0000, 0x0400_0000, 0x0000_0000 -> res_max=0x0400_0000 and res_idx=0 (tie keeps earliest).
REQ-040 Scenario: start with len=0 -> err high for one cycle and busy stays 0; a following start with len=1 and input 0xFF00_0000 -> res_max=0xFF00_0000 and res_idx=0.
REQ-041 Scenario: len=2 with 3-cycle in_valid gaps, res_ready held 0 for 5 cycles and start pulsed in DONE -> result stays stable, in_ready=0, no err, and IDLE follows the res_ready cycle.
REQ-042 Scenario: reset asserted after 2 of 4 elements -> all outputs 0 at once, res_valid never pulses, and the next len=1 operation completes correctly.
